// File: rtl/vga_fill_controller_pkg.sv
// Shared types and screen geometry for the VGA rectangle-fill controller.
// Coordinates are sized to the adapter ports: 8-bit x and 7-bit y.
package vga_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [7:0] coord_x_t;
    typedef logic [6:0] coord_y_t;
    typedef logic [2:0] colour_t;

    localparam coord_x_t X_MAX        = coord_x_t'(SCREEN_W - 1);
    localparam coord_y_t Y_MAX        = coord_y_t'(SCREEN_H - 1);
    localparam colour_t  CLEAR_COLOUR = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

    typedef struct packed {
        coord_x_t x0;
        coord_y_t y0;
        coord_x_t x1;
        coord_y_t y1;
        colour_t  colour;
    } rect_t;

    function automatic logic on_screen(input coord_x_t x, input coord_y_t y);
        return (x <= X_MAX) && (y <= Y_MAX);
    endfunction

endpackage

// File: rtl/vga_fill_controller_if.sv
// Command handshake and framebuffer-adapter drive signals of the fill controller.
// The controller side uses the slave modport; the command source uses master.
interface vga_fill_controller_if;
    import vga_pkg::*;

    logic     Cmd_valid;
    logic     Cmd_ready;
    coord_x_t Cmd_x0;
    coord_y_t Cmd_y0;
    coord_x_t Cmd_x1;
    coord_y_t Cmd_y1;
    colour_t  Cmd_colour;
    logic     Clear_req;
    logic     Abort;
    colour_t  Colour;
    coord_x_t Fill_x;
    coord_y_t Fill_y;
    logic     Fill_plot;
    logic     Busy;
    logic     Done;

    modport slave (
        input  Cmd_valid, Cmd_x0, Cmd_y0, Cmd_x1, Cmd_y1, Cmd_colour, Clear_req, Abort,
        output Cmd_ready, Colour, Fill_x, Fill_y, Fill_plot, Busy, Done
    );

    modport master (
        output Cmd_valid, Cmd_x0, Cmd_y0, Cmd_x1, Cmd_y1, Cmd_colour, Clear_req, Abort,
        input  Cmd_ready, Colour, Fill_x, Fill_y, Fill_plot, Busy, Done
    );

endinterface

// File: rtl/vga_rect_scan.sv
// Row-major raster counters: load jumps to (x0,y0), step advances one pixel.
// Registered position; o_nx/o_ny expose the position the next edge will hold.
module vga_rect_scan
    import vga_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_load,
    input  logic     i_step,
    input  coord_x_t i_x0,
    input  coord_y_t i_y0,
    input  coord_x_t i_x1,
    input  coord_y_t i_y1,
    output coord_x_t o_x,
    output coord_y_t o_y,
    output coord_x_t o_nx,
    output coord_y_t o_ny,
    output logic     o_last
);

    coord_x_t r_x, r_x0, r_x1;
    coord_y_t r_y, r_y1;
    coord_x_t w_nx;
    coord_y_t w_ny;

    always_comb begin
        w_nx = r_x;
        w_ny = r_y;
        if (i_load) begin
            w_nx = i_x0;
            w_ny = i_y0;
        end else if (i_step) begin
            if (r_x == r_x1) begin
                w_nx = r_x0;
                w_ny = r_y + 7'd1;
            end else begin
                w_nx = r_x + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_x0 <= '0;
            r_x1 <= '0;
            r_y1 <= '0;
        end else begin
            r_x <= w_nx;
            r_y <= w_ny;
            if (i_load) begin
                r_x0 <= i_x0;
                r_x1 <= i_x1;
                r_y1 <= i_y1;
            end
        end
    end

    // Equality rather than range test, so x1/y1 at the counter maximum never wraps.
    assign o_last = (r_x == r_x1) && (r_y == r_y1);
    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_nx   = w_nx;
    assign o_ny   = w_ny;

endmodule

// File: rtl/vga_fill_controller.sv
// Rectangle/clear fill sequencer for the 160x120 adapter; first pixel the cycle after acceptance, one pixel per clock.
// Cmd_ready drops outside IDLE, under Abort or Clear_req; VGA_FILL_CLIP_EN clamps coordinates at acceptance.
module vga_fill_controller
    import vga_pkg::*;
(
    input logic                  Clock,
    input logic                  Reset_n,
    vga_fill_controller_if.slave bus
);

    fill_state_e r_state, w_state_nxt;
    colour_t     r_colour;
    logic        r_plot, r_busy, r_done;
    logic        w_plot_nxt, w_busy_nxt, w_done_nxt;
    logic        w_start, w_empty, w_load, w_step, w_last;
    rect_t       w_rect;
    coord_x_t    w_x, w_nx;
    coord_y_t    w_y, w_ny;

    always_comb begin
        if (bus.Clear_req) begin
            w_rect = '{x0: '0, y0: '0, x1: X_MAX, y1: Y_MAX, colour: CLEAR_COLOUR};
        end else begin
            w_rect = '{x0: bus.Cmd_x0, y0: bus.Cmd_y0, x1: bus.Cmd_x1,
                       y1: bus.Cmd_y1, colour: bus.Cmd_colour};
        end
`ifdef VGA_FILL_CLIP_EN
        if (w_rect.x0 > X_MAX) w_rect.x0 = X_MAX;
        if (w_rect.x1 > X_MAX) w_rect.x1 = X_MAX;
        if (w_rect.y0 > Y_MAX) w_rect.y0 = Y_MAX;
        if (w_rect.y1 > Y_MAX) w_rect.y1 = Y_MAX;
`endif
    end

    // Clear wins over a simultaneous command, which stays pending until IDLE returns.
    assign bus.Cmd_ready = (r_state == IDLE) && !bus.Abort && !bus.Clear_req;
    assign w_start = (r_state == IDLE) && !bus.Abort && (bus.Clear_req || bus.Cmd_valid);
    assign w_empty = (w_rect.x0 > w_rect.x1) || (w_rect.y0 > w_rect.y1);
    assign w_load  = w_start && !w_empty;
    assign w_step  = (r_state == FILL) && !bus.Abort && !w_last;

    vga_rect_scan u_scan (
        .clk    (Clock),
        .rst_n  (Reset_n),
        .i_load (w_load),
        .i_step (w_step),
        .i_x0   (w_rect.x0),
        .i_y0   (w_rect.y0),
        .i_x1   (w_rect.x1),
        .i_y1   (w_rect.y1),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_nx   (w_nx),
        .o_ny   (w_ny),
        .o_last (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_plot_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (w_empty) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = FILL;
                        w_busy_nxt  = 1'b1;
                        w_plot_nxt  = on_screen(w_nx, w_ny);
                    end
                end
            end
            FILL: begin
                if (bus.Abort || w_last) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_plot_nxt = on_screen(w_nx, w_ny);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_plot  <= w_plot_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_start) r_colour <= w_rect.colour;
        end
    end

    assign bus.Colour    = r_colour;
    assign bus.Fill_x    = w_x;
    assign bus.Fill_y    = w_y;
    assign bus.Fill_plot = r_plot;
    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;

endmodule

// File: tb/tb_vga_fill_controller.sv
// Self-checking bench for vga_fill_controller: table of rectangles plus clear, abort and reset sequences.
// Expected pixels come from a raster model pushed to a queue and popped as Fill_plot appears.
module tb_vga_fill_controller;

    logic clk;
    logic rst_n;

    vga_fill_controller_if bus();

    vga_fill_controller dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x0;
        int y0;
        int x1;
        int y1;
        int col;
        int exp_plots;
        int exp_busy;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;

    px_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push_rect(input int x0, input int y0, input int x1, input int y1, input int col);
        int ax0, ay0, ax1, ay1;
        ax0 = x0; ay0 = y0; ax1 = x1; ay1 = y1;
`ifdef VGA_FILL_CLIP_EN
        if (ax0 > 159) ax0 = 159;
        if (ax1 > 159) ax1 = 159;
        if (ay0 > 119) ay0 = 119;
        if (ay1 > 119) ay1 = 119;
`endif
        for (int y = ay0; y <= ay1; y++)
            for (int x = ax0; x <= ax1; x++)
                if (x < 160 && y < 120) exp_q.push_back('{x: x, y: y, c: col});
    endtask

    // Starts at a falling edge with the DUT idle; returns one cycle after the Done pulse.
    task automatic do_fill(input logic clr, input logic keep_vld,
                           input int x0, input int y0, input int x1, input int y1, input int col,
                           input int abort_at,
                           output int plots, output int busy, output int first_cyc,
                           output int done_cyc, output int ready_seen);
        int  cyc;
        px_t e;
        bus.Clear_req  = clr;
        bus.Cmd_valid  = !clr || keep_vld;
        bus.Cmd_x0     = 8'(x0);
        bus.Cmd_y0     = 7'(y0);
        bus.Cmd_x1     = 8'(x1);
        bus.Cmd_y1     = 7'(y1);
        bus.Cmd_colour = 3'(col);
        if (clr) push_rect(0, 0, 159, 119, 0);
        else     push_rect(x0, y0, x1, y1, col);
        #1;
        check(clr ? "ready_with_clear" : "ready_idle", int'(bus.Cmd_ready), clr ? 0 : 1);
        plots = 0; busy = 0; first_cyc = -1; done_cyc = -1; ready_seen = 0; cyc = 0;
        while (done_cyc < 0 && cyc < 25000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.Clear_req = 1'b0;
                if (!keep_vld) bus.Cmd_valid = 1'b0;
            end
            bus.Abort = 1'b0;
            #1;
            if (bus.Fill_plot) begin
                plots++;
                if (first_cyc < 0) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("pixel_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", int'(bus.Fill_x) * 1024 + int'(bus.Fill_y) * 8 + int'(bus.Colour),
                          e.x * 1024 + e.y * 8 + e.c);
                end
            end
            if (bus.Busy) busy++;
            if (bus.Cmd_ready) ready_seen++;
            if (bus.Done) done_cyc = cyc;
            if (abort_at > 0 && bus.Fill_plot && plots == abort_at) bus.Abort = 1'b1;
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
        bus.Abort = 1'b0;
        if (abort_at > 0) exp_q.delete();
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        #1;
        check("done_single_cycle", int'(bus.Done), 0);
        check("idle_busy", int'(bus.Busy), 0);
        if (keep_vld) check("ready_after_done", int'(bus.Cmd_ready), 1);
    endtask

    vec_t vecs[7];

    initial begin
        int plots, busy, first_cyc, done_cyc, ready_seen, seen;

        vecs[0] = '{x0: 2,   y0: 3,   x1: 4,   y1: 4,   col: 5, exp_plots: 6, exp_busy: 6};
        vecs[1] = '{x0: 10,  y0: 10,  x1: 5,   y1: 5,   col: 1, exp_plots: 0, exp_busy: 0};
        vecs[2] = '{x0: 159, y0: 119, x1: 159, y1: 119, col: 7, exp_plots: 1, exp_busy: 1};
        vecs[3] = '{x0: 0,   y0: 0,   x1: 0,   y1: 3,   col: 2, exp_plots: 4, exp_busy: 4};
        vecs[4] = '{x0: 5,   y0: 7,   x1: 12,  y1: 7,   col: 3, exp_plots: 8, exp_busy: 8};
`ifdef VGA_FILL_CLIP_EN
        vecs[5] = '{x0: 158, y0: 118, x1: 200, y1: 127, col: 6, exp_plots: 4, exp_busy: 4};
`else
        vecs[5] = '{x0: 158, y0: 118, x1: 200, y1: 127, col: 6, exp_plots: 4, exp_busy: 430};
`endif
        vecs[6] = '{x0: 10,  y0: 5,   x1: 5,   y1: 9,   col: 4, exp_plots: 0, exp_busy: 0};

        rst_n = 1'b0;
        bus.Cmd_valid = 1'b0; bus.Clear_req = 1'b0; bus.Abort = 1'b0;
        bus.Cmd_x0 = '0; bus.Cmd_y0 = '0; bus.Cmd_x1 = '0; bus.Cmd_y1 = '0; bus.Cmd_colour = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_colour", int'(bus.Colour), 0);
        check("rst_x", int'(bus.Fill_x), 0);
        check("rst_y", int'(bus.Fill_y), 0);
        check("rst_busy", int'(bus.Busy), 0);
        check("rst_done", int'(bus.Done), 0);
        check("rst_ready", int'(bus.Cmd_ready), 1);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            seen += int'(bus.Fill_plot);
        end
        check("rst_no_plot", seen, 0);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            do_fill(1'b0, 1'b0, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].col, 0,
                    plots, busy, first_cyc, done_cyc, ready_seen);
            check($sformatf("v%0d_plots", i), plots, vecs[i].exp_plots);
            check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("v%0d_done_cyc", i), done_cyc, vecs[i].exp_busy + 1);
            check($sformatf("v%0d_first_plot", i), first_cyc, (vecs[i].exp_plots > 0) ? 1 : -1);
        end

        // Abort while idle: nothing is accepted and no Done appears.
        @(negedge clk);
        bus.Abort = 1'b1; bus.Cmd_valid = 1'b1;
        bus.Cmd_x0 = 8'd1; bus.Cmd_y0 = 7'd1; bus.Cmd_x1 = 8'd2; bus.Cmd_y1 = 7'd2;
        #1;
        check("abort_idle_ready", int'(bus.Cmd_ready), 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            seen += int'(bus.Busy) + int'(bus.Done) + int'(bus.Fill_plot);
        end
        check("abort_idle_quiet", seen, 0);
        bus.Abort = 1'b0; bus.Cmd_valid = 1'b0;

        // Clear with a command pending: clear runs first, command follows after DONE.
        @(negedge clk);
        do_fill(1'b1, 1'b1, 2, 3, 4, 4, 5, 0, plots, busy, first_cyc, done_cyc, ready_seen);
        check("clear_plots", plots, 19200);
        check("clear_busy", busy, 19200);
        check("clear_ready_low", ready_seen, 0);
        do_fill(1'b0, 1'b0, 2, 3, 4, 4, 5, 0, plots, busy, first_cyc, done_cyc, ready_seen);
        check("pending_cmd_plots", plots, 6);
        check("pending_cmd_first", first_cyc, 1);

        // Abort after the third plot.
        @(negedge clk);
        do_fill(1'b0, 1'b0, 0, 0, 9, 9, 2, 3, plots, busy, first_cyc, done_cyc, ready_seen);
        check("abort_plots", plots, 3);
        check("abort_busy", busy, 3);
        check("abort_done_cyc", done_cyc, 4);

        // Asynchronous reset in the middle of a fill.
        @(negedge clk);
        bus.Cmd_valid = 1'b1; bus.Cmd_colour = 3'd3;
        bus.Cmd_x0 = 8'd0; bus.Cmd_y0 = 7'd0; bus.Cmd_x1 = 8'd9; bus.Cmd_y1 = 7'd9;
        @(negedge clk);
        bus.Cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("midfill_busy_before", int'(bus.Busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_plot", int'(bus.Fill_plot), 0);
        check("midrst_busy", int'(bus.Busy), 0);
        check("midrst_x", int'(bus.Fill_x), 0);
        check("midrst_colour", int'(bus.Colour), 0);
        check("midrst_done", int'(bus.Done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            seen += int'(bus.Done) + int'(bus.Fill_plot);
        end
        check("midrst_no_done", seen, 0);
        check("midrst_ready", int'(bus.Cmd_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
